// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared encodings for the time-multiplexed DDS channel core
package dds_pkg;

  typedef enum logic [1:0] {
    CFG_TUNING = 2'd0,
    CFG_OFFSET = 2'd1,
    CFG_AMP    = 2'd2,
    CFG_SHAPE  = 2'd3
  } cfg_sel_e;

  typedef enum logic [1:0] {
    SHAPE_SINE   = 2'd0,
    SHAPE_SQUARE = 2'd1,
    SHAPE_TRI    = 2'd2,
    SHAPE_SAW    = 2'd3
  } shape_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_LUT   = 3'd2,
    ST_SCALE = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/dds_sine_lut.sv
// rtl/dds_sine_lut.sv - full-wave offset-binary sine from a quarter-wave table, 1-cycle read
module dds_sine_lut #(
  parameter int LUT_ADDR_W = 10,
  parameter int OUT_W      = 12
) (
  input  logic                  clk,
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic [OUT_W-1:0]      data
);

  localparam int     Q_N     = 2 ** (LUT_ADDR_W - 2);
  localparam int     MAG_W   = OUT_W - 1;
  localparam int     MAG_MAX = 2 ** MAG_W - 1;
  localparam longint ONE_Q30 = 64'sd1 << 30;
  localparam longint PI_Q30  = 64'sd3373259426;
  localparam logic [OUT_W-1:0] HALF = OUT_W'(1) << (OUT_W - 1);

  // Samples sit half a step off the axes so the quarter folds without a special peak entry.
  function automatic logic [MAG_W-1:0] quarter_sine(input int idx);
    longint x, x2, term, sum;
    x    = (PI_Q30 * longint'(2 * idx + 1)) / longint'(4 * Q_N);
    x2   = (x * x) / ONE_Q30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) / ONE_Q30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return MAG_W'((sum * longint'(MAG_MAX) + ONE_Q30 / 2) / ONE_Q30);
  endfunction

  logic [MAG_W-1:0] qtab [Q_N];

  for (genvar i = 0; i < Q_N; i++) begin : g_tab
    assign qtab[i] = quarter_sine(i);
  end

  logic [1:0]            quad;
  logic [LUT_ADDR_W-3:0] low;
  logic [LUT_ADDR_W-3:0] idx;
  logic [MAG_W-1:0]      mag;

  assign quad = addr[LUT_ADDR_W-1 -: 2];
  assign low  = addr[LUT_ADDR_W-3:0];
  assign idx  = quad[0] ? ~low : low;
  assign mag  = qtab[idx];

  always_ff @(posedge clk) begin
    data <= quad[1] ? (HALF - {1'b0, mag}) : (HALF + {1'b0, mag});
  end

endmodule

// File: rtl/dds_channel_core.sv
// rtl/dds_channel_core.sv - time-multiplexed multi-channel DDS with shadowed config and valid/ready output
module dds_channel_core
  import dds_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int PHASE_W    = 24,
  parameter int LUT_ADDR_W = 10,
  parameter int OUT_W      = 12,
  parameter int AMP_W      = 11,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_sel,
  input  logic [PHASE_W-1:0] cfg_data,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [OUT_W-1:0]   out_data,
  output logic               overrun
);

  localparam int P_KEEP = (LUT_ADDR_W > OUT_W + 1) ? LUT_ADDR_W : OUT_W + 1;
  localparam int PROD_W = OUT_W + AMP_W + 1;

  state_e              state;
  logic [CH_W-1:0]     ch;
  logic [P_KEEP-1:0]   phase_top;
  logic [PHASE_W-1:0]  phase_sum;

  logic [PHASE_W-1:0]  acc     [CHANNELS];
  logic [PHASE_W-1:0]  tun_act [CHANNELS];
  logic [PHASE_W-1:0]  tun_sh  [CHANNELS];
  logic [PHASE_W-1:0]  tun_nx  [CHANNELS];
  logic [PHASE_W-1:0]  off_act [CHANNELS];
  logic [PHASE_W-1:0]  off_sh  [CHANNELS];
  logic [PHASE_W-1:0]  off_nx  [CHANNELS];
  logic [AMP_W-1:0]    amp_act [CHANNELS];
  logic [AMP_W-1:0]    amp_sh  [CHANNELS];
  logic [AMP_W-1:0]    amp_nx  [CHANNELS];
  shape_e              shp_act [CHANNELS];
  shape_e              shp_sh  [CHANNELS];
  shape_e              shp_nx  [CHANNELS];

  logic                wr_ok;
  logic [OUT_W-1:0]    lut_data;
  logic [OUT_W-1:0]    u_val;
  logic signed [OUT_W-1:0]  s_val;
  logic signed [PROD_W-1:0] prod;
  logic [OUT_W-1:0]    scaled;

  assign wr_ok = cfg_we && (32'(cfg_ch) < CHANNELS);

  // Shadows as they stand after this cycle's write, so a tick in the same cycle commits it.
  always_comb begin
    tun_nx = tun_sh;
    off_nx = off_sh;
    amp_nx = amp_sh;
    shp_nx = shp_sh;
    if (wr_ok) begin
      case (cfg_sel_e'(cfg_sel))
        CFG_TUNING: tun_nx[cfg_ch] = cfg_data;
        CFG_OFFSET: off_nx[cfg_ch] = cfg_data;
        CFG_AMP:    amp_nx[cfg_ch] = cfg_data[AMP_W-1:0];
        CFG_SHAPE:  shp_nx[cfg_ch] = shape_e'(cfg_data[1:0]);
      endcase
    end
  end

  assign phase_sum = acc[ch] + off_act[ch];

  dds_sine_lut #(
    .LUT_ADDR_W (LUT_ADDR_W),
    .OUT_W      (OUT_W)
  ) u_lut (
    .clk  (clk),
    .addr (phase_top[P_KEEP-1 -: LUT_ADDR_W]),
    .data (lut_data)
  );

  always_comb begin
    u_val = lut_data;
    case (shp_act[ch])
      SHAPE_SINE:   u_val = lut_data;
      SHAPE_SQUARE: u_val = {OUT_W{phase_top[P_KEEP-1]}};
      SHAPE_TRI:    u_val = phase_top[P_KEEP-1] ? ~phase_top[P_KEEP-2 -: OUT_W]
                                                :  phase_top[P_KEEP-2 -: OUT_W];
      SHAPE_SAW:    u_val = phase_top[P_KEEP-1 -: OUT_W];
    endcase
  end

  // Flipping the MSB converts between offset binary and two's complement.
  assign s_val  = {~u_val[OUT_W-1], u_val[OUT_W-2:0]};
  assign prod   = $signed({{(AMP_W + 1){s_val[OUT_W-1]}}, s_val})
                * $signed({{(OUT_W + 1){1'b0}}, amp_act[ch]});
  assign scaled = OUT_W'(prod >>> AMP_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ch        <= '0;
      phase_top <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      overrun   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]     <= '0;
        tun_act[i] <= '0;
        tun_sh[i]  <= '0;
        off_act[i] <= '0;
        off_sh[i]  <= '0;
        amp_act[i] <= '0;
        amp_sh[i]  <= '0;
        shp_act[i] <= SHAPE_SINE;
        shp_sh[i]  <= SHAPE_SINE;
      end
    end else begin
      tun_sh <= tun_nx;
      off_sh <= off_nx;
      amp_sh <= amp_nx;
      shp_sh <= shp_nx;
      if (sample_tick && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (sample_tick) begin
            tun_act <= tun_nx;
            off_act <= off_nx;
            amp_act <= amp_nx;
            shp_act <= shp_nx;
            ch      <= '0;
            busy    <= 1'b1;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          phase_top <= P_KEEP'(phase_sum >> (PHASE_W - P_KEEP));
          acc[ch]   <= acc[ch] + tun_act[ch];
          state     <= ST_LUT;
        end
        ST_LUT:   state <= ST_SCALE;
        ST_SCALE: begin
          out_data  <= {~scaled[OUT_W-1], scaled[OUT_W-2:0]};
          out_ch    <= ch;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ch == CH_W'(CHANNELS - 1)) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              ch    <= ch + CH_W'(1);
              state <= ST_CALC;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_channel_core.sv
// tb/tb_dds_channel_core.sv - self-checking bench for dds_channel_core against a frame-level model
module tb_dds_channel_core;

  localparam int CHANNELS   = 2;
  localparam int PHASE_W    = 24;
  localparam int LUT_ADDR_W = 10;
  localparam int OUT_W      = 12;
  localparam int AMP_W      = 11;
  localparam int CH_W       = 1;
  localparam int HALF       = 1 << (OUT_W - 1);
  localparam real PI        = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_tick;
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [1:0]         cfg_sel;
  logic [PHASE_W-1:0] cfg_data;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [CH_W-1:0]    out_ch;
  logic [OUT_W-1:0]   out_data;
  logic               overrun;

  dds_channel_core #(
    .CHANNELS   (CHANNELS),
    .PHASE_W    (PHASE_W),
    .LUT_ADDR_W (LUT_ADDR_W),
    .OUT_W      (OUT_W),
    .AMP_W      (AMP_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_data    (out_data),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural reference: sine from the real-valued function, floor division for scaling.
  function automatic int sine_ref(input int a);
    real ang, v;
    int  r;
    ang = 2.0 * PI * (real'(a) + 0.5) / real'(1 << LUT_ADDR_W);
    v   = real'(HALF - 1) * $sin(ang);
    r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    return HALF + r;
  endfunction

  function automatic int model_sample(input int shape, input logic [PHASE_W-1:0] p, input int amp);
    logic [OUT_W-1:0] t;
    int     u, s;
    longint prod, q;
    t = p[PHASE_W-2 -: OUT_W];
    case (shape)
      0:       u = sine_ref(int'(p[PHASE_W-1 -: LUT_ADDR_W]));
      1:       u = p[PHASE_W-1] ? (2 * HALF - 1) : 0;
      2:       u = p[PHASE_W-1] ? (2 * HALF - 1) - int'(t) : int'(t);
      default: u = int'(p[PHASE_W-1 -: OUT_W]);
    endcase
    s    = u - HALF;
    prod = longint'(s) * longint'(amp);
    q    = prod / longint'(1 << AMP_W);
    if (prod < 0 && (prod % longint'(1 << AMP_W)) != 0) q = q - 1;
    return int'(q) + HALF;
  endfunction

  logic [PHASE_W-1:0] m_acc [CHANNELS];
  logic [PHASE_W-1:0] a_tun [CHANNELS];
  logic [PHASE_W-1:0] a_off [CHANNELS];
  logic [PHASE_W-1:0] s_tun [CHANNELS];
  logic [PHASE_W-1:0] s_off [CHANNELS];
  int a_amp [CHANNELS];
  int s_amp [CHANNELS];
  int a_shp [CHANNELS];
  int s_shp [CHANNELS];
  int exp_c [$];
  int exp_d [$];
  int m_pending = 0;
  int m_wait = 0;
  bit m_valid = 1'b0;
  bit m_overrun = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int c = 0; c < CHANNELS; c++) begin
          m_acc[c] = '0; a_tun[c] = '0; a_off[c] = '0; s_tun[c] = '0; s_off[c] = '0;
          a_amp[c] = 0; s_amp[c] = 0; a_shp[c] = 0; s_shp[c] = 0;
        end
        exp_c.delete();
        exp_d.delete();
        m_pending = 0;
        m_wait    = 0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
      end else begin
        if (cfg_we && int'(cfg_ch) < CHANNELS) begin
          case (cfg_sel)
            2'd0: s_tun[cfg_ch] = cfg_data;
            2'd1: s_off[cfg_ch] = cfg_data;
            2'd2: s_amp[cfg_ch] = int'(cfg_data) % (1 << AMP_W);
            default: s_shp[cfg_ch] = int'(cfg_data) % 4;
          endcase
        end
        if (sample_tick) begin
          if (m_pending == 0) begin
            for (int c = 0; c < CHANNELS; c++) begin
              a_tun[c] = s_tun[c]; a_off[c] = s_off[c];
              a_amp[c] = s_amp[c]; a_shp[c] = s_shp[c];
            end
            for (int c = 0; c < CHANNELS; c++) begin
              exp_c.push_back(c);
              exp_d.push_back(model_sample(a_shp[c], m_acc[c] + a_off[c], a_amp[c]));
              m_acc[c] = m_acc[c] + a_tun[c];
            end
            m_pending = CHANNELS;
            m_wait    = 4;
          end else begin
            m_overrun = 1'b1;
          end
        end
        if (m_valid && out_ready) begin
          void'(exp_c.pop_front());
          void'(exp_d.pop_front());
          m_pending--;
          m_valid = 1'b0;
          if (m_pending > 0) m_wait = 4;
        end
        if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_busy", busy, m_pending != 0);
      chk("cyc_valid", out_valid, m_valid);
      chk("cyc_overrun", overrun, m_overrun);
      if (m_valid && exp_d.size() > 0) begin
        chk("cyc_out_ch", out_ch, exp_c[0]);
        chk("cyc_out_data", out_data, exp_d[0]);
      end
    end
  end

  int got_c [$];
  int got_d [$];

  task automatic cfg_write(input int c, input int sel, input int data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = CH_W'(c); cfg_sel = 2'(sel); cfg_data = PHASE_W'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic tick_cfg(input int c, input int sel, input int data);
    @(negedge clk);
    sample_tick = 1'b1;
    cfg_we = 1'b1; cfg_ch = CH_W'(c); cfg_sel = 2'(sel); cfg_data = PHASE_W'(data);
    @(negedge clk);
    sample_tick = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      if (out_valid && out_ready) begin
        got_c.push_back(int'(out_ch));
        got_d.push_back(int'(out_data));
      end
      @(negedge clk);
      n++;
    end
    chk("frame_done_in_budget", n < 200, 1);
  endtask

  task automatic frame();
    do_tick();
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    rst = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_sel = '0; cfg_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;

    do_tick();
    chk("lat_t1_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    chk("lat_t3_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_t4_valid", out_valid, 1);
    chk("lat_t4_ch", out_ch, 0);
    chk("lat_t4_data", out_data, 2048);
    wait_idle();
    chk("f0_count", got_d.size(), 2);
    chk("f0_ch1_ch", got_c[1], 1);
    chk("f0_ch1_data", got_d[1], 2048);
    chk("f0_busy_low", busy, 0);

    cfg_write(0, 3, 3);
    cfg_write(0, 0, 'h100000);
    cfg_write(0, 2, 2047);
    cfg_write(1, 3, 1);
    cfg_write(1, 1, 'h800000);
    cfg_write(1, 2, 2047);
    got_c.delete(); got_d.delete();
    repeat (17) frame();
    chk("saw_f1", got_d[0], 1);
    chk("saw_f2", got_d[2], 256);
    chk("saw_f17_wrap", got_d[32], 1);
    chk("sq_f1", got_d[1], 4094);
    chk("sq_f17", got_d[33], 4094);

    cfg_write(1, 2, 0);
    got_c.delete(); got_d.delete();
    frame();
    chk("saw_f18", got_d[0], 256);
    chk("sq_amp0", got_d[1], 2048);

    got_c.delete(); got_d.delete();
    out_ready = 1'b0;
    do_tick();
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_ch !== 0 || out_data !== 12'd512) bad++;
      sample_tick = (i == 4);
      @(negedge clk);
    end
    sample_tick = 1'b0;
    chk("hold_unstable_cycles", bad, 0);
    chk("hold_overrun", overrun, 1);
    out_ready = 1'b1;
    wait_idle();
    chk("hold_data", got_d[0], 512);
    got_c.delete(); got_d.delete();
    frame();
    chk("single_advance", got_d[0], 768);

    got_c.delete(); got_d.delete();
    do_tick();
    cfg_write(0, 2, 1024);
    wait_idle();
    chk("amp_mid_frame_cur", got_d[0], 1024);
    got_c.delete(); got_d.delete();
    frame();
    chk("amp_mid_frame_next", got_d[0], 1664);
    got_c.delete(); got_d.delete();
    tick_cfg(0, 2, 512);
    wait_idle();
    chk("amp_coincident", got_d[0], 1920);

    do_tick();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_overrun", overrun, 0);
    rst = 1'b0;

    cfg_write(0, 3, 3);
    cfg_write(0, 0, 'h100000);
    cfg_write(0, 2, 2047);
    cfg_write(1, 1, 'h400000);
    cfg_write(1, 2, 2047);
    got_c.delete(); got_d.delete();
    frame();
    chk("restart_phase0", got_d[0], 1);
    chk("sine_peak", got_d[1], 4094);

    cfg_write(1, 0, 'h012345);
    cfg_write(0, 3, 2);
    cfg_write(0, 1, 'h0ABCDE);
    repeat (10) frame();
    cfg_write(1, 3, 2);
    cfg_write(0, 2, 700);
    cfg_write(0, 3, 0);
    repeat (8) frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_channel_core.md
DDS_CHANNEL_CORE -- requirements
Module: dds_channel_core

Interface
REQ-001 CHANNELS, default 2, number of time-multiplexed DDS channels, range 1..8.
REQ-002 PHASE_W, default 24, phase accumulator width; SHALL satisfy PHASE_W >= OUT_W+1 and PHASE_W >= LUT_ADDR_W.
REQ-003 LUT_ADDR_W, default 10, phase bits used to address the sine table.
REQ-004 OUT_W, default 12, output sample width, offset binary.
REQ-005 AMP_W, default 11, amplitude register width; 2^AMP_W-1 is approximately unity gain.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 sample_tick  in  1  one-cycle strobe that starts a frame of one sample per channel.
REQ-009 cfg_we  in  1  config write strobe.
REQ-010 cfg_ch  in  max(1,clog2(CHANNELS))  target channel; writes with cfg_ch >= CHANNELS are ignored.
REQ-011 cfg_sel  in  2  register select: 0 tuning word, 1 phase offset, 2 amplitude (low AMP_W bits), 3 shape (low 2 bits).
REQ-012 cfg_data  in  PHASE_W  write data.
REQ-013 busy  out  1  high while a frame is in progress.
REQ-014 out_valid  out  1  sample available.
REQ-015 out_ready  in  1  consumer accepts the sample; a transfer occurs when out_valid and out_ready are both high.
REQ-016 out_ch  out  max(1,clog2(CHANNELS))  channel index of the sample.
REQ-017 out_data  out  OUT_W  sample value.
REQ-018 overrun  out  1  sticky; set when a sample_tick arrives while busy.

Function
REQ-019 Config writes SHALL land in per-channel shadow registers; active registers SHALL be loaded from the shadows only when a sample_tick is accepted.
REQ-020 If cfg_we and an accepted sample_tick occur in the same cycle, the write SHALL be included in the commit.
REQ-021 FSM states: IDLE, CALC, LUT, SCALE, OUT.
- IDLE -> CALC on sample_tick; channel index = 0.
- CALC -> LUT -> SCALE, one cycle each.
- SCALE -> OUT.
- OUT: on transfer, go to CALC with the next channel, or to IDLE after channel CHANNELS-1.
REQ-022 CALC SHALL compute p = (acc[ch] + offset[ch]) mod 2^PHASE_W from the pre-update accumulator, then set acc[ch] = (acc[ch] + tuning[ch]) mod 2^PHASE_W. Accumulators SHALL wrap silently.
REQ-023 The unsigned raw value u (OUT_W bits) SHALL be selected by shape:
- 0 sine: dds_sine_lut(p[PHASE_W-1 -: LUT_ADDR_W]).
- 1 square: p MSB ? all-ones : 0.
- 2 triangle: p MSB ? ~p[PHASE_W-2 -: OUT_W] : p[PHASE_W-2 -: OUT_W].
- 3 sawtooth: p[PHASE_W-1 -: OUT_W].
REQ-024 Scaling SHALL compute s = u - 2^(OUT_W-1) (signed), then out_data = ((s*amp) >>> AMP_W) + 2^(OUT_W-1), where >>> is an arithmetic (floor) shift; the result cannot overflow.
REQ-025 out_valid SHALL go high in the first cycle of OUT, i.e. 4 cycles after the sample_tick cycle for channel 0.
REQ-026 While out_valid is high and out_ready is low, out_valid, out_ch and out_data SHALL hold stable.
REQ-027 out_valid SHALL deassert in the cycle after a transfer.
REQ-028 busy SHALL be high in every state except IDLE.
REQ-029 A sample_tick while busy SHALL be ignored and SHALL set overrun; it SHALL NOT commit shadows or advance accumulators.

Reset
REQ-030 rst SHALL, from any state including mid-frame, force IDLE on the next edge.
REQ-031 On reset: out_valid=0, busy=0, overrun=0, out_ch=0, out_data=0; all accumulators, tuning words, offsets and amplitudes (active and shadow) = 0; shape = 0 (sine).
REQ-032 rst SHALL take priority over sample_tick and cfg_we.

Structure
REQ-033 Package dds_pkg SHALL hold the cfg_sel encodings, shape encodings and the FSM state enum.
REQ-034 Sub-module dds_sine_lut: full-wave sine from a quarter-wave table, registered 1-cycle read, LUT_ADDR_W-bit address, OUT_W-bit offset-binary output.

Verification (defaults)
REQ-035 Reset, then sample_tick with out_ready=1: out_valid high at tick+4 with ch0, data 2048; ch1 follows with data 2048; busy drops after the second transfer.
REQ-036 ch0 sawtooth, tuning 0x100000, amp 2047, offset 0: frame 1 data = 1, frame 2 data = 256, frame 17 wraps to data 1.
REQ-037 ch1 square, offset 0x800000, amp 2047: data 4094 each frame; with amp 0: data 2048.
REQ-038 Hold out_ready low for 10 cycles with a second sample_tick during that time: outputs stay stable, overrun=1, and the next frame shows only one accumulator advance.
REQ-039 Write ch0 amp 1024 mid-frame: current frame unchanged; next frame uses the new amplitude. Also check a write coincident with sample_tick takes effect immediately.
REQ-040 Assert rst during SCALE of ch1: next cycle out_valid=0, busy=0, and the following frame restarts from phase 0.
